// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and FSM state type for the streaming SHA-256
// message padder and its combinational pad-insertion helper.
package sha256_pkg;

  localparam int         BLOCK_BITS     = 512;
  localparam int         LEN_FIELD_BITS = 64;
  localparam logic [7:0] PAD_BYTE       = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EMIT_PAD
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_insert.sv
// sha256_pad_insert: combinational block former. Bytes below i_end are taken
// from the buffer, byte i_end optionally becomes the 0x80 marker, and bytes
// 56..63 optionally carry the big-endian message bit length. Everything else
// is forced to zero so no stale data can leak into a block.
module sha256_pad_insert
  import sha256_pkg::*;
#(
  parameter int LEN_W = 13
) (
  input  logic [BLOCK_BITS-1:0] i_buf,
  input  logic [6:0]            i_end,
  input  logic                  i_put80,
  input  logic                  i_write_len,
  input  logic [LEN_W-1:0]      i_msg_len,
  output logic [BLOCK_BITS-1:0] o_block
);

  logic [LEN_FIELD_BITS-1:0] w_len_field;

  assign w_len_field = LEN_FIELD_BITS'(i_msg_len) << 3;

  // Assemble each output byte from data, marker, length field or zero.
  always_comb begin
    o_block = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(i_end)) begin
        o_block[8*(63-i) +: 8] = i_buf[8*(63-i) +: 8];
      end else if ((i == int'(i_end)) && i_put80) begin
        o_block[8*(63-i) +: 8] = PAD_BYTE;
      end else if ((i >= 56) && i_write_len) begin
        o_block[8*(63-i) +: 8] = w_len_field[8*(63-i) +: 8];
      end
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streaming FIPS 180-4 message padder. Collects message
// bytes into a 64-byte buffer, emits full data blocks, and appends the 0x80
// marker and 64-bit length, spilling into an extra pad block when needed.
// Optional feature macro SHA256_PAD_LIMIT_EN: saturating length counter with
// a sticky len_error that clears on the next message's first beat.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int DATA_BYTES    = 1,
  parameter int MAX_MSG_BYTES = 4096
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [8*DATA_BYTES-1:0]         in_data,
  input  logic                            in_last,
  input  logic [$clog2(DATA_BYTES+1)-1:0] in_bytes,
  output logic                            block_valid,
  input  logic                            block_ready,
  output logic [BLOCK_BITS-1:0]           block_data,
  output logic                            block_last,
  output logic                            len_error
);

  localparam int LEN_W  = $clog2(MAX_MSG_BYTES + 1);
  localparam int LEN_W1 = LEN_W + 1;

  pad_state_t            r_state;
  pad_state_t            w_state_next;
  logic [BLOCK_BITS-1:0] r_buf;
  logic [BLOCK_BITS-1:0] w_merged;
  logic [BLOCK_BITS-1:0] w_padded;
  logic [BLOCK_BITS-1:0] w_ins_buf;
  logic [5:0]            r_ptr;
  logic [LEN_W-1:0]      r_msg_len;
  logic [LEN_W-1:0]      w_len_next;
  logic [LEN_W-1:0]      w_ins_len;
  logic                  r_block_last;
  logic                  r_pad_pending;
  logic                  r_pad80_pending;
  logic [6:0]            w_n;
  logic [6:0]            w_end;
  logic [6:0]            w_ins_end;
  logic                  w_ins_put80;
  logic                  w_ins_write_len;
  logic                  w_accept;
  logic                  w_handshake;

  assign w_accept    = in_valid && reset && (r_state == FILL);
  assign w_handshake = block_valid && block_ready;
  assign w_n         = in_last ? 7'(in_bytes) : 7'(DATA_BYTES);
  assign w_end       = {1'b0, r_ptr} + w_n;
  assign block_data  = r_buf;
  assign block_last  = r_block_last;

`ifdef SHA256_PAD_LIMIT_EN
  logic [LEN_W1-1:0] w_len_sum;
  logic              w_over;
  logic              w_first;
  logic              r_len_error;

  assign w_len_sum  = {1'b0, r_msg_len} + LEN_W1'(w_n);
  assign w_over     = w_len_sum > LEN_W1'(MAX_MSG_BYTES);
  assign w_len_next = w_over ? LEN_W'(MAX_MSG_BYTES) : w_len_sum[LEN_W-1:0];
  assign w_first    = (r_ptr == 6'd0) && (r_msg_len == '0);
  assign len_error  = r_len_error;

  // Sticky overflow flag; a new message's first beat starts it afresh.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_len_error <= 1'b0;
    end else if (w_accept) begin
      r_len_error <= (w_first ? 1'b0 : r_len_error) | w_over;
    end
  end
`else
  assign w_len_next = r_msg_len + LEN_W'(w_n);
  assign len_error  = 1'b0;
`endif

  // Drop the incoming beat into the buffer at the current byte pointer.
  always_comb begin
    w_merged = r_buf;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if ((i < int'(w_n)) && ((int'(r_ptr) + i) < 64)) begin
        w_merged[8*(63 - int'(r_ptr) - i) +: 8] = in_data[8*(DATA_BYTES-1-i) +: 8];
      end
    end
  end

  // Feed the inserter with the live message tail in FILL, or an empty pad block otherwise.
  always_comb begin
    if (r_state == FILL) begin
      w_ins_buf       = w_merged;
      w_ins_end       = w_end;
      w_ins_put80     = (w_end < 7'd64);
      w_ins_write_len = (w_end <= 7'd55);
      w_ins_len       = w_len_next;
    end else begin
      w_ins_buf       = '0;
      w_ins_end       = '0;
      w_ins_put80     = r_pad80_pending;
      w_ins_write_len = 1'b1;
      w_ins_len       = r_msg_len;
    end
  end

  sha256_pad_insert #(
    .LEN_W(LEN_W)
  ) u_pad_insert (
    .i_buf      (w_ins_buf),
    .i_end      (w_ins_end),
    .i_put80    (w_ins_put80),
    .i_write_len(w_ins_write_len),
    .i_msg_len  (w_ins_len),
    .o_block    (w_padded)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    block_valid  = 1'b0;
    unique case (r_state)
      FILL: begin
        in_ready = reset;
        if (w_accept && (in_last || (w_end == 7'd64))) begin
          w_state_next = EMIT;
        end
      end
      EMIT: begin
        block_valid = 1'b1;
        if (block_ready) begin
          w_state_next = r_pad_pending ? EMIT_PAD : FILL;
        end
      end
      EMIT_PAD: begin
        block_valid = 1'b1;
        if (block_ready) begin
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // Buffer, pointer, length and pad bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_buf           <= '0;
      r_ptr           <= '0;
      r_msg_len       <= '0;
      r_block_last    <= 1'b0;
      r_pad_pending   <= 1'b0;
      r_pad80_pending <= 1'b0;
    end else if (w_accept) begin
      r_msg_len <= w_len_next;
      if (in_last) begin
        r_buf           <= w_padded;
        r_ptr           <= '0;
        r_block_last    <= (w_end <= 7'd55);
        r_pad_pending   <= (w_end > 7'd55);
        r_pad80_pending <= (w_end == 7'd64);
      end else begin
        r_buf <= w_merged;
        r_ptr <= w_end[5:0];
      end
    end else if (w_handshake) begin
      if ((r_state == EMIT) && r_pad_pending) begin
        r_buf           <= w_padded;
        r_block_last    <= 1'b1;
        r_pad_pending   <= 1'b0;
        r_pad80_pending <= 1'b0;
      end else begin
        r_buf        <= '0;
        r_block_last <= 1'b0;
        if (r_block_last) begin
          r_msg_len <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: randomized bench for the SHA-256 message padder with
// a byte-level padding reference model. Covers 1-byte and 8-byte beat widths;
// with SHA256_PAD_LIMIT_EN a third instance exercises the length limit.
module tb_sha256_msg_padder;

`ifdef SHA256_PAD_LIMIT_EN
  localparam int NDUT = 3;
`else
  localparam int NDUT = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [NDUT-1:0]        inValid;
  logic [NDUT-1:0]        inReady;
  logic [NDUT-1:0]        inLast;
  logic [NDUT-1:0]        blockValid;
  logic [NDUT-1:0]        blockReady;
  logic [NDUT-1:0]        blockLast;
  logic [NDUT-1:0]        lenError;
  logic [NDUT-1:0][63:0]  inData;
  logic [NDUT-1:0][6:0]   inBytes;
  logic [NDUT-1:0][511:0] blockData;

  byte unsigned msgQ[$];
  logic [511:0] expQ[$];
  int checks = 0;
  int errors = 0;

  // Free-running clock.
  always #5 clock = ~clock;

  sha256_msg_padder #(.DATA_BYTES(1), .MAX_MSG_BYTES(4096)) u_dut1 (
    .clock(clock), .reset(reset),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0][63:56]),
    .in_last(inLast[0]), .in_bytes(inBytes[0][0:0]),
    .block_valid(blockValid[0]), .block_ready(blockReady[0]), .block_data(blockData[0]),
    .block_last(blockLast[0]), .len_error(lenError[0])
  );

  sha256_msg_padder #(.DATA_BYTES(8), .MAX_MSG_BYTES(4096)) u_dut8 (
    .clock(clock), .reset(reset),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
    .in_last(inLast[1]), .in_bytes(inBytes[1][3:0]),
    .block_valid(blockValid[1]), .block_ready(blockReady[1]), .block_data(blockData[1]),
    .block_last(blockLast[1]), .len_error(lenError[1])
  );

`ifdef SHA256_PAD_LIMIT_EN
  sha256_msg_padder #(.DATA_BYTES(1), .MAX_MSG_BYTES(64)) u_dutLim (
    .clock(clock), .reset(reset),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2][63:56]),
    .in_last(inLast[2]), .in_bytes(inBytes[2][0:0]),
    .block_valid(blockValid[2]), .block_ready(blockReady[2]), .block_data(blockData[2]),
    .block_last(blockLast[2]), .len_error(lenError[2])
  );
`endif

  function automatic int dbOf(input int d);
    return (d == 1) ? 8 : 1;
  endfunction

  function automatic int maxOf(input int d);
    return (d == 2) ? 64 : 4096;
  endfunction

  function automatic int lenWOf(input int d);
    return $clog2(maxOf(d) + 1);
  endfunction

  // Reference: textbook padding of the whole message, then cut into 64-byte blocks.
  task automatic buildExpected(input int d);
    byte unsigned p[$];
    longint lenVal;
    int L;
    logic [511:0] blk;
    L = msgQ.size();
    p = msgQ;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
`ifdef SHA256_PAD_LIMIT_EN
    lenVal = (L > maxOf(d)) ? longint'(maxOf(d)) : longint'(L);
`else
    lenVal = longint'(L % (1 << lenWOf(d)));
`endif
    lenVal = lenVal * 8;
    for (int k = 7; k >= 0; k--) p.push_back(8'(lenVal >> (8*k)));
    expQ.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[8*(63-j) +: 8] = p[64*b + j];
      expQ.push_back(blk);
    end
  endtask

  task automatic fillMsg(input int len, input bit randData);
    msgQ.delete();
    for (int i = 0; i < len; i++) msgQ.push_back(randData ? 8'($urandom_range(0, 255)) : 8'h41);
  endtask

  task automatic fillAbc();
    msgQ.delete();
    msgQ.push_back(8'h61);
    msgQ.push_back(8'h62);
    msgQ.push_back(8'h63);
  endtask

  // Stream msgQ into instance d and check every emitted block against the model.
  task automatic runMsg(input int d, input int stall, input string name);
    int db, L, sent, got, cyc, stallLeft, n;
    bit msgDone, expValid, last, expErr;
    logic [511:0] held;
    db = dbOf(d);
    L = msgQ.size();
    sent = 0; got = 0; cyc = 0; stallLeft = stall;
    msgDone = 0; expValid = 0; held = '0;
    buildExpected(d);
`ifdef SHA256_PAD_LIMIT_EN
    expErr = (L > maxOf(d));
`else
    expErr = 1'b0;
`endif
    while (got < expQ.size()) begin
      @(negedge clock);
      cyc++;
      if (cyc > 3000) begin
        checks++; errors++;
        $display("FAIL %s timeout: got %0d blocks, expected %0d", name, got, expQ.size());
        break;
      end
      inValid[d] = 1'b0;
      blockReady[d] = 1'b0;
      if (expValid) begin
        checks++;
        if (blockValid[d] !== 1'b1) begin
          errors++;
          $display("FAIL %s latency: block_valid=%b expected 1", name, blockValid[d]);
        end
        expValid = 0;
      end
      if (blockValid[d] === 1'b1) begin
        checks++;
        if (inReady[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready while emitting: got %b expected 0", name, inReady[d]);
        end
        if (stallLeft > 0) begin
          if (stallLeft == stall) held = blockData[d];
          else begin
            checks++;
            if (blockData[d] !== held) begin
              errors++;
              $display("FAIL %s stall stability: got %h expected %h", name, blockData[d], held);
            end
          end
          stallLeft--;
        end else begin
          checks++;
          if (blockData[d] !== expQ[got]) begin
            errors++;
            $display("FAIL %s block%0d data: got %h expected %h", name, got, blockData[d], expQ[got]);
          end
          checks++;
          if (blockLast[d] !== (got == expQ.size() - 1)) begin
            errors++;
            $display("FAIL %s block%0d last: got %b expected %b", name, got, blockLast[d], (got == expQ.size() - 1));
          end
          if (got == expQ.size() - 1) begin
            checks++;
            if (lenError[d] !== expErr) begin
              errors++;
              $display("FAIL %s len_error: got %b expected %b", name, lenError[d], expErr);
            end
          end
          blockReady[d] = 1'b1;
          got++;
          stallLeft = stall;
          if (msgDone && (got == expQ.size() - 1)) expValid = 1;
        end
      end else if (!msgDone && (inReady[d] === 1'b1)) begin
        n = ((L - sent) < db) ? (L - sent) : db;
        last = ((L - sent) <= db);
        inData[d] = {$urandom, $urandom};
        for (int j = 0; j < n; j++) inData[d][63-8*j -: 8] = msgQ[sent + j];
        inBytes[d] = last ? 7'(n) : 7'($urandom_range(0, 127));
        inLast[d] = last;
        inValid[d] = 1'b1;
        sent += n;
        if (last) msgDone = 1;
        if (last || ((sent % 64) == 0)) expValid = 1;
      end
    end
    @(negedge clock);
    blockReady[d] = 1'b0;
    inValid[d] = 1'b0;
    checks++;
    if ((inReady[d] !== 1'b1) || (blockValid[d] !== 1'b0)) begin
      errors++;
      $display("FAIL %s idle after message: in_ready=%b block_valid=%b expected 1/0", name, inReady[d], blockValid[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ((inReady[d] !== 1'b0) || (blockValid[d] !== 1'b0) || (blockData[d] !== '0) ||
          (blockLast[d] !== 1'b0) || (lenError[d] !== 1'b0)) begin
        errors++;
        $display("FAIL reset dut%0d: rdy=%b vld=%b last=%b err=%b data=%h expected all zero",
                 d, inReady[d], blockValid[d], blockLast[d], lenError[d], blockData[d]);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (inReady[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset release dut%0d in_ready: got %b expected 1", d, inReady[d]);
      end
    end
  endtask

  task automatic test_abc();
    fillAbc();
    runMsg(0, 0, "abc_db1");
    fillAbc();
    runMsg(1, 1, "abc_db8");
  endtask

  task automatic test_boundaries();
    int lens[5] = '{0, 55, 56, 63, 64};
    foreach (lens[i]) begin
      fillMsg(lens[i], 1'b0);
      runMsg(0, 0, $sformatf("bound_db1_len%0d", lens[i]));
    end
  endtask

  task automatic test_back_to_back();
    int lens[5] = '{64, 0, 57, 120, 128};
    foreach (lens[i]) begin
      fillMsg(lens[i], 1'b1);
      runMsg(1, i % 2, $sformatf("b2b_db8_len%0d", lens[i]));
    end
  endtask

  task automatic test_random();
    int d, len;
    for (int k = 0; k < 12; k++) begin
      d = k % 2;
      len = $urandom_range(0, 200);
      fillMsg(len, 1'b1);
      runMsg(d, $urandom_range(0, 3), $sformatf("rand%0d_dut%0d_len%0d", k, d, len));
    end
  endtask

  task automatic test_backpressure_reset();
    logic [511:0] held;
    fillMsg(64, 1'b1);
    buildExpected(0);
    blockReady[0] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      checks++;
      if (inReady[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp fill in_ready byte%0d: got %b expected 1", i, inReady[0]);
      end
      inValid[0] = 1'b1;
      inLast[0] = 1'b0;
      inBytes[0] = '0;
      inData[0][63:56] = msgQ[i];
    end
    @(negedge clock);
    inValid[0] = 1'b0;
    checks++;
    if ((blockValid[0] !== 1'b1) || (blockData[0] !== expQ[0]) || (blockLast[0] !== 1'b0)) begin
      errors++;
      $display("FAIL bp first block: vld=%b last=%b data=%h expected 1/0 %h",
               blockValid[0], blockLast[0], blockData[0], expQ[0]);
    end
    held = blockData[0];
    repeat (5) begin
      @(negedge clock);
      checks++;
      if ((blockData[0] !== held) || (inReady[0] !== 1'b0) || (blockValid[0] !== 1'b1)) begin
        errors++;
        $display("FAIL bp hold: data=%h rdy=%b vld=%b expected %h 0 1", blockData[0], inReady[0], blockValid[0], held);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ((inReady[0] !== 1'b0) || (blockValid[0] !== 1'b0) || (blockData[0] !== '0) ||
        (blockLast[0] !== 1'b0) || (lenError[0] !== 1'b0)) begin
      errors++;
      $display("FAIL bp mid-message reset: rdy=%b vld=%b last=%b err=%b data=%h expected all zero",
               inReady[0], blockValid[0], blockLast[0], lenError[0], blockData[0]);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (inReady[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp reset release in_ready: got %b expected 1", inReady[0]);
    end
    fillAbc();
    runMsg(0, 0, "abc_after_reset");
  endtask

`ifdef SHA256_PAD_LIMIT_EN
  task automatic test_limit();
    fillMsg(65, 1'b1);
    runMsg(2, 0, "limit_len65");
    checks++;
    if (lenError[2] !== 1'b1) begin
      errors++;
      $display("FAIL limit sticky between messages: got %b expected 1", lenError[2]);
    end
    fillAbc();
    runMsg(2, 0, "limit_next_abc");
  endtask
`endif

  initial begin
    inValid = '0;
    inLast = '0;
    blockReady = '0;
    inData = '0;
    inBytes = '0;
    test_reset();
    test_abc();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_backpressure_reset();
`ifdef SHA256_PAD_LIMIT_EN
    test_limit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
